// File: rtl/uart_ctrl_pkg.sv
// Shared types and default sizing for the UART frame controller, its wrapper and bench.
package uart_ctrl_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned N_IN_DEF        = 17;
  localparam int unsigned N_OUT_DEF       = 32;
  localparam int unsigned ADDR_W_DEF      = 6;
  localparam int unsigned TIMEOUT_CYC_DEF = 250000;

  typedef enum logic [2:0] {
    RX_HI     = 3'd0,
    RX_LO     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RD        = 3'd4,
    RD_WAIT   = 3'd5,
    TX_HI     = 3'd6,
    TX_LO     = 3'd7
  } state_e;

endpackage

// File: rtl/uart_word_assembler.sv
// Packs received byte pairs (high first) into input-buffer writes.
// UART_RX_TIMEOUT_EN adds an inter-byte timeout that drops a half-received word.
module uart_word_assembler
  import uart_ctrl_pkg::*;
#(
`ifdef UART_RX_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              rx_valid_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              last_o,
  output logic              idle_nxt_c
);

  state_e              phase_q, phase_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]   wcnt_q, wcnt_d, addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d, last_q, last_d;
  logic                rx_take;
  logic                tmo_hit;

  // The cycle after the final write is still "receive" for the top FSM; drop bytes there.
  assign rx_take = en_i && rx_valid_i && !last_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_run;

  assign tmo_run = en_i && !last_q && ((phase_q == RX_LO) || (wcnt_q != '0));
  assign tmo_hit = tmo_run && !rx_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (!tmo_run || rx_valid_i || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    last_d  = 1'b0;
    if (tmo_hit) begin
      phase_d = RX_HI;
      hi_d    = '0;
      wcnt_d  = '0;
    end else if (rx_take) begin
      if (phase_q == RX_LO) begin
        we_d    = 1'b1;
        addr_d  = wcnt_q;
        wdata_d = DATA_W'({hi_q, rx_data_i});
        phase_d = RX_HI;
        if (wcnt_q == ADDR_W'(N_IN - 1)) begin
          wcnt_d = '0;
          last_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + ADDR_W'(1);
        end
      end else begin
        hi_d    = rx_data_i;
        phase_d = RX_LO;
      end
    end
    idle_nxt_c = (phase_d == RX_HI) && (wcnt_d == '0) && !last_d;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= RX_HI;
      hi_q    <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      last_q  <= last_d;
    end
  end

  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign last_o  = last_q;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer: UART RX words -> input buffer, core start/done, result words -> UART TX.
// UART_RX_TIMEOUT_EN enables the inter-byte receive timeout in the word assembler.
module uart_frame_ctrl
  import uart_ctrl_pkg::*;
#(
`ifdef UART_RX_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned N_OUT  = N_OUT_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              in_we,
  output logic [ADDR_W-1:0] in_addr,
  output logic [DATA_W-1:0] in_wdata,
  output logic              core_start,
  input  logic              core_done,
  output logic              out_re,
  output logic [ADDR_W-1:0] out_addr,
  input  logic [DATA_W-1:0] out_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ocnt_q, ocnt_d, out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                core_start_q, core_start_d;
  logic                out_re_q, out_re_d;
  logic                busy_q, busy_d;
  logic                frame_done;
  logic                rx_idle_nxt_c;

  // While state_q is RX_HI the assembler owns the high/low byte sub-phase.
  uart_word_assembler #(
`ifdef UART_RX_TIMEOUT_EN
    .TIMEOUT_CYC(TIMEOUT_CYC),
`endif
    .DATA_W(DATA_W),
    .N_IN  (N_IN),
    .ADDR_W(ADDR_W)
  ) u_asm (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .en_i      (state_q == RX_HI),
    .rx_valid_i(rx_valid),
    .rx_data_i (rx_data),
    .we_o      (in_we),
    .addr_o    (in_addr),
    .wdata_o   (in_wdata),
    .last_o    (frame_done),
    .idle_nxt_c(rx_idle_nxt_c)
  );

  always_comb begin
    state_d    = state_q;
    ocnt_d     = ocnt_q;
    word_d     = word_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    out_addr_d = out_addr_q;
    unique case (state_q)
      RX_HI:     if (frame_done) state_d = START;
      START: begin
        ocnt_d  = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (core_done) state_d = RD;
      RD:        state_d = RD_WAIT;
      RD_WAIT: begin
        word_d     = out_rdata;
        tx_data_d  = out_rdata[DATA_W-1 -: BYTE_W];
        tx_valid_d = 1'b1;
        state_d    = TX_HI;
      end
      TX_HI: begin
        tx_valid_d = 1'b1;
        if (tx_valid_q && tx_ready) begin
          tx_data_d = word_q[BYTE_W-1:0];
          state_d   = TX_LO;
        end
      end
      TX_LO: begin
        tx_valid_d = 1'b1;
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (ocnt_q == ADDR_W'(N_OUT - 1)) begin
            ocnt_d  = '0;
            state_d = RX_HI;
          end else begin
            ocnt_d  = ocnt_q + ADDR_W'(1);
            state_d = RD;
          end
        end
      end
      default:   state_d = RX_HI;
    endcase
    // Strobes are Moore outputs of the next state so they line up with the state cycle.
    core_start_d = (state_d == START);
    out_re_d     = (state_d == RD);
    if (state_d == RD) out_addr_d = ocnt_d;
    busy_d = !((state_d == RX_HI) && rx_idle_nxt_c);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_HI;
      ocnt_q       <= '0;
      word_q       <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      core_start_q <= 1'b0;
      out_re_q     <= 1'b0;
      out_addr_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ocnt_q       <= ocnt_d;
      word_q       <= word_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      core_start_q <= core_start_d;
      out_re_q     <= out_re_d;
      out_addr_q   <= out_addr_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign core_start = core_start_q;
  assign out_re     = out_re_q;
  assign out_addr   = out_addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: frame receive, result streaming, stalls, drops, reset.
module tb_uart_frame_ctrl;
  import uart_ctrl_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;

  logic          sysclk    = 1'b0;
  logic          rst_n     = 1'b0;
  logic          rx_valid  = 1'b0;
  logic [7:0]    rx_data   = 8'h00;
  logic          tx_ready  = 1'b0;
  logic          core_done = 1'b0;
  logic [DW-1:0] out_rdata = '0;
  logic          tx_valid, in_we, core_start, out_re, busy;
  logic [7:0]    tx_data;
  logic [AW-1:0] in_addr, out_addr;
  logic [DW-1:0] in_wdata;

  int tests = 0;
  int fails = 0;

  always #5 sysclk = ~sysclk;

  uart_frame_ctrl #(
`ifdef UART_RX_TIMEOUT_EN
    .TIMEOUT_CYC(1000),
`endif
    .DATA_W(DW), .N_IN(N_IN_DEF), .N_OUT(N_OUT_DEF), .ADDR_W(AW)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .in_we(in_we), .in_addr(in_addr), .in_wdata(in_wdata),
    .core_start(core_start), .core_done(core_done),
    .out_re(out_re), .out_addr(out_addr), .out_rdata(out_rdata), .busy(busy)
  );

  // Result buffer: word k holds 0xA500 + k, one cycle read latency.
  always @(posedge sysclk) if (out_re) out_rdata <= 16'hA500 + DW'(out_addr);

  int            cyc = 0;
  int            wr_n = 0, tx_n = 0, start_n = 0, re_n = 0;
  int            last_we_cyc = 0, start_cyc = 0;
  logic [AW-1:0] wr_addr [256];
  logic [DW-1:0] wr_data [256];
  logic [7:0]    tx_byte [512];

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (in_we) begin
      if (wr_n < 256) begin
        wr_addr[wr_n] <= in_addr;
        wr_data[wr_n] <= in_wdata;
      end
      wr_n        <= wr_n + 1;
      last_we_cyc <= cyc;
    end
    if (core_start) begin
      start_n   <= start_n + 1;
      start_cyc <= cyc;
    end
    if (out_re) re_n <= re_n + 1;
    if (tx_valid && tx_ready) begin
      if (tx_n < 512) tx_byte[tx_n] <= tx_data;
      tx_n <= tx_n + 1;
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo0);
    for (int k = 0; k < int'(N_IN_DEF); k++) begin
      send_byte(hi);
      send_byte(lo0 + 8'(k));
    end
  endtask

  task automatic pulse_done();
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic wait_tx(input int target, output logic expired);
    int n;
    expired = 1'b1;
    n = 0;
    while (n < 3000 && expired) begin
      if (tx_n >= target) expired = 1'b0;
      else tick();
      n++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({tx_valid, tx_data, in_we, in_addr, in_wdata, core_start, out_re, out_addr, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got tx_valid=%b tx_data=%h in_we=%b in_addr=%0d in_wdata=%h core_start=%b out_re=%b out_addr=%0d busy=%b, want all 0",
               tx_valid, tx_data, in_we, in_addr, in_wdata, core_start, out_re, out_addr, busy);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_rx_frame();
    int w0, s0;
    w0 = wr_n;
    s0 = start_n;
    send_frame(8'h12, 8'h34);
    repeat (3) tick();
    tests++;
    if (wr_n - w0 != 17) begin
      fails++;
      $display("FAIL rx_write_count: got %0d want 17", wr_n - w0);
    end
    for (int k = 0; k < 17; k++) begin
      tests++;
      if (wr_addr[w0+k] !== AW'(k) || wr_data[w0+k] !== 16'h1234 + 16'(k)) begin
        fails++;
        $display("FAIL rx_write_%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 k, wr_addr[w0+k], wr_data[w0+k], k, 16'h1234 + 16'(k));
      end
    end
    tests++;
    if (start_n - s0 != 1) begin
      fails++;
      $display("FAIL rx_start_count: got %0d want 1", start_n - s0);
    end
    tests++;
    if (start_cyc != last_we_cyc + 1) begin
      fails++;
      $display("FAIL rx_start_latency: got start at %0d, last write %0d, want write+1", start_cyc, last_we_cyc);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rx_busy: got %b want 1", busy);
    end
  endtask

  task automatic test_tx_stream();
    int t0, r0;
    logic expired;
    logic [7:0] exp;
    t0 = tx_n;
    r0 = re_n;
    tx_ready = 1'b1;
    repeat (100) tick();
    pulse_done();
    tick();
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL tx_early: got tx_valid=%b two cycles after done, want 0", tx_valid);
    end
    tick();
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL tx_latency: got tx_valid=%b tx_data=%h three cycles after done, want 1/a5", tx_valid, tx_data);
    end
    wait_tx(t0 + 64, expired);
    tests++;
    if (expired) begin
      fails++;
      $display("FAIL tx_timeout: got %0d bytes want 64", tx_n - t0);
    end
    for (int i = 0; i < 64; i++) begin
      exp = (i % 2 == 0) ? 8'hA5 : 8'(i / 2);
      tests++;
      if (tx_byte[t0+i] !== exp) begin
        fails++;
        $display("FAIL tx_byte_%0d: got %h want %h", i, tx_byte[t0+i], exp);
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || re_n - r0 != 32) begin
      fails++;
      $display("FAIL tx_end: got busy=%b tx_valid=%b reads=%0d want 0/0/32", busy, tx_valid, re_n - r0);
    end
  endtask

  task automatic test_tx_stall();
    int t0, r0, bad;
    logic expired;
    send_frame(8'h20, 8'h00);
    tx_ready = 1'b0;
    repeat (10) tick();
    t0 = tx_n;
    pulse_done();
    tick();
    tick();
    r0 = re_n;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || re_n != r0 || out_addr !== '0) bad++;
      tick();
    end
    tests++;
    if (bad != 0 || tx_n != t0) begin
      fails++;
      $display("FAIL stall_hold: got %0d unstable cycles, %0d bytes, tx_data=%h, want 0/0/a5", bad, tx_n - t0, tx_data);
    end
    tx_ready = 1'b1;
    wait_tx(t0 + 64, expired);
    tests++;
    if (expired || tx_byte[t0] !== 8'hA5 || tx_byte[t0+1] !== 8'h00 || tx_byte[t0+63] !== 8'h1F) begin
      fails++;
      $display("FAIL stall_resume: got %0d bytes first=%h second=%h last=%h want 64/a5/00/1f",
               tx_n - t0, tx_byte[t0], tx_byte[t0+1], tx_byte[t0+63]);
    end
    repeat (2) tick();
  endtask

  task automatic test_drop_bytes();
    int w0, w1, t0;
    logic expired;
    w0 = wr_n;
    send_frame(8'h30, 8'h00);
    repeat (3) tick();
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    tests++;
    if (wr_n - w0 != 17 || busy !== 1'b1) begin
      fails++;
      $display("FAIL drop_wait_done: got %0d writes busy=%b want 17/1", wr_n - w0, busy);
    end
    tx_ready = 1'b0;
    t0 = tx_n;
    pulse_done();
    tick();
    tick();
    send_byte(8'h11);
    send_byte(8'h22);
    tests++;
    if (wr_n - w0 != 17 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL drop_tx: got %0d writes tx_valid=%b tx_data=%h want 17/1/a5", wr_n - w0, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    wait_tx(t0 + 64, expired);
    tests++;
    if (expired || tx_byte[t0+63] !== 8'h1F) begin
      fails++;
      $display("FAIL drop_drain: got %0d bytes last=%h want 64/1f", tx_n - t0, tx_byte[t0+63]);
    end
    repeat (2) tick();
    w1 = wr_n;
    send_frame(8'h55, 8'h00);
    repeat (3) tick();
    tests++;
    if (wr_n - w1 != 17 || wr_addr[w1] !== '0 || wr_data[w1] !== 16'h5500 ||
        wr_addr[w1+16] !== AW'(16) || wr_data[w1+16] !== 16'h5510) begin
      fails++;
      $display("FAIL drop_next_frame: got %0d writes first=%0d:%h last=%0d:%h want 17 0:5500 16:5510",
               wr_n - w1, wr_addr[w1], wr_data[w1], wr_addr[w1+16], wr_data[w1+16]);
    end
    t0 = tx_n;
    pulse_done();
    wait_tx(t0 + 64, expired);
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int w0, w1, s0, t0;
    logic expired;
    w0 = wr_n;
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h40);
      send_byte(8'(k));
    end
    send_byte(8'h41);
    tests++;
    if (wr_n - w0 != 5) begin
      fails++;
      $display("FAIL mid_prewrites: got %0d want 5", wr_n - w0);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if ({tx_valid, tx_data, in_we, in_addr, in_wdata, core_start, out_re, out_addr, busy} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got in_we=%b in_addr=%0d in_wdata=%h busy=%b want all 0",
               in_we, in_addr, in_wdata, busy);
    end
    rst_n = 1'b1;
    tick();
    w1 = wr_n;
    s0 = start_n;
    send_frame(8'h60, 8'h00);
    repeat (3) tick();
    tests++;
    if (wr_n - w1 != 17 || start_n - s0 != 1 || wr_addr[w1] !== '0 || wr_data[w1] !== 16'h6000 ||
        wr_addr[w1+16] !== AW'(16) || wr_data[w1+16] !== 16'h6010) begin
      fails++;
      $display("FAIL mid_restart: got %0d writes %0d starts first=%0d:%h last=%0d:%h want 17 1 0:6000 16:6010",
               wr_n - w1, start_n - s0, wr_addr[w1], wr_data[w1], wr_addr[w1+16], wr_data[w1+16]);
    end
    t0 = tx_n;
    pulse_done();
    wait_tx(t0 + 64, expired);
    tests++;
    if (expired) begin
      fails++;
      $display("FAIL mid_drain: got %0d bytes want 64", tx_n - t0);
    end
    repeat (2) tick();
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_timeout();
    int w0;
    w0 = wr_n;
    send_byte(8'h77);
    repeat (1005) tick();
    send_byte(8'hBE);
    send_byte(8'hEF);
    repeat (2) tick();
    tests++;
    if (wr_n - w0 != 1 || wr_addr[w0] !== '0 || wr_data[w0] !== 16'hBEEF) begin
      fails++;
      $display("FAIL timeout_resync: got %0d writes first=%0d:%h want 1 0:beef", wr_n - w0, wr_addr[w0], wr_data[w0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rx_frame();
    test_tx_stream();
    test_tx_stall();
    test_drop_bytes();
    test_reset_mid();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sequencer between the UART byte engines (RX/TX) and the ECG classifier core.
- Assembles received byte pairs into 16-bit words (high byte first) and writes N_IN words into the input buffer.
- Then pulses the core start, waits for done, reads N_OUT result words and streams each back as two bytes (high byte first).
- Sits inside the UART wrapper, between the rx/tx byte modules and the core/buffers.

Parameters:
- DATA_W, 16, word width; fixed to 2 bytes.
- N_IN, 17, words received per frame.
- N_OUT, 32, result words transmitted per frame.
- ADDR_W, 6, buffer address width; must satisfy 2^ADDR_W >= max(N_IN, N_OUT).
- TIMEOUT_CYC, 250000, inter-byte timeout in sysclk cycles (used only with the optional feature).

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  async active-low reset
- rx_valid  in  1  one-cycle strobe: new byte from UART RX
- rx_data  in  8  received byte
- tx_ready  in  1  UART TX idle, can accept a byte
- tx_valid  out  1  byte offered to TX
- tx_data  out  8  byte to transmit
- in_we  out  1  input buffer write enable
- in_addr  out  ADDR_W  input buffer address
- in_wdata  out  DATA_W  input buffer write data
- core_start  out  1  one-cycle start pulse to classifier
- core_done  in  1  classifier finished (level or pulse)
- out_re  out  1  result buffer read enable
- out_addr  out  ADDR_W  result buffer address
- out_rdata  in  DATA_W  result data, valid 1 cycle after out_re
- busy  out  1  high in any state except RX_HI with word count 0

Behaviour:
- Reset (async, rst_n=0):
  - State RX_HI; word/byte counters 0; hi-byte register 0.
  - All outputs 0: tx_valid, tx_data, in_we, in_addr, in_wdata, core_start, out_re, out_addr, busy.
- States: RX_HI, RX_LO, START, WAIT_DONE, RD, RD_WAIT, TX_HI, TX_LO.
- RX_HI: on rx_valid, latch rx_data into hi_byte, go to RX_LO.
- RX_LO: on rx_valid:
  - Next cycle: in_we=1 for exactly 1 cycle, in_wdata={hi_byte, rx_data}, in_addr=word count.
  - Increment word count.
  - If count reaches N_IN, go to START; else return to RX_HI.
- rx_valid outside RX_HI/RX_LO is ignored and dropped.
- START: core_start=1 for one cycle; clear counter; go to WAIT_DONE.
- WAIT_DONE: wait for core_done=1, then go to RD. core_done in any other state is ignored.
- RD: out_re=1 for one cycle, out_addr=counter; go to RD_WAIT.
- RD_WAIT: capture out_rdata into tx shift register; go to TX_HI.
- TX_HI: tx_valid=1, tx_data=word[15:8]; hold both stable until the cycle tx_valid && tx_ready, then go to TX_LO.
- TX_LO: same handshake with word[7:0]. After it:
  - Increment counter.
  - If counter == N_OUT: clear counter, go to RX_HI (ready for the next frame).
  - Else go to RD.
- Latencies:
  - Byte to buffer write: 1 cycle after the low byte's rx_valid.
  - Done to first tx_valid: 3 cycles (RD, RD_WAIT, TX_HI).
- Simultaneous tx_ready and state entry: handshake may complete in the first TX_HI cycle.
- Reset mid-frame aborts everything; no partial writes are completed.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Enabled:
  - Counter runs in RX_LO, or in RX_HI when word count > 0; cleared on each rx_valid.
  - On reaching TIMEOUT_CYC-1: word count and hi_byte cleared, state to RX_HI, no write issued. This resyncs the host after a lost byte.
- Disabled: no counter is synthesised; the controller waits indefinitely for bytes.

Decomposition:
- Package uart_ctrl_pkg:
  - State enum encoding.
  - BYTE_W=8.
  - Default N_IN/N_OUT/DATA_W constants, shared with the wrapper and the bench.
- One natural sub-module: uart_word_assembler, covering the RX_HI/RX_LO byte-pair packing and the timeout. Its output is a word_valid/word strobe.
- Top-level FSM handles the core handshake and TX.

Test Plan:
- 17 byte pairs 0x12,0x34 … (word k = 0x1234+k) -> 17 in_we pulses, addr 0..16, data 0x1234..0x1244; core_start pulses once 1 cycle after the last write.
- core_done after 100 cycles, result mem word k = 0xA500+k, tx_ready tied 1 -> 64 tx handshakes in order A5,00,A5,01,…,A5,1F; busy falls after the last one.
- tx_ready held 0 for 50 cycles during TX_HI -> tx_valid/tx_data stable at 0xA5, no address advance; resumes when ready rises.
- rx_valid bytes injected during WAIT_DONE and TX -> no in_we, no state change; a second frame afterwards is received correctly at addr 0.
- rst_n asserted after 5 words, then a full frame -> outputs 0 during reset; writes restart at addr 0, exactly 17 writes, one core_start.
- With UART_RX_TIMEOUT_EN, TIMEOUT_CYC=1000: high byte only, idle 1000 cycles, then a full pair 0xBE,0xEF -> single write of 0xBEEF at addr 0.
